// File: rtl/core_seq_pkg.sv
// Shared types and instruction-word layout for the core sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package core_seq_pkg;

    // ARM is a one-cycle setup step. It reloads the address counters from the
    // bases that were just latched.
    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_W_RD,
        S_W_LD,
        S_W_DRAIN,
        S_X_RD,
        S_EXEC,
        S_WB,
        S_SFP_RD,
        S_DONE
    } state_t;

    localparam int INST_W        = 34;
    localparam int INST_ACC      = 33;
    localparam int INST_CEN_P    = 32;
    localparam int INST_WEN_P    = 31;
    localparam int INST_A_P_LSB  = 20;
    localparam int INST_CEN_X    = 19;
    localparam int INST_WEN_X    = 18;
    localparam int INST_A_X_LSB  = 7;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_L0_RD    = 3;
    localparam int INST_L0_WR    = 2;
    localparam int INST_EXEC     = 1;
    localparam int INST_LOAD     = 0;

    // Both SRAMs are deselected with write-enable high. Every other bit is 0.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

endpackage

// File: rtl/seq_addr_cnt.sv
// Address stream generator: addr = base + offset, with wrap mod 2^AW.
// Latency: addr is combinational from the offset register; the offset steps once per inc.
// Backpressure: none; the caller pulses inc only when an access is issued.
module seq_addr_cnt #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] limit,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [AW-1:0] off;

    // Offset register. Clear wins over inc so a stream can be rearmed on its final access.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            off <= '0;
        end else if (inc) begin
            off <= off + AW'(1);
        end
    end

    assign addr = base + off;
    assign last = (off == limit - AW'(1));

endmodule

// File: rtl/core_sequencer.sv
// Tile sequencer: weight load, activation execute, and OFIFO->psum writeback inst stream for core.
// Latency: start->done = 2*COL + DRAIN_CYC + 2*n_act + WB cycles + 3; inst lags the FSM by one cycle.
// Backpressure: WB stalls indefinitely on ofifo_valid. SEQ_SFP_RD_EN adds a psum read-back (acc) pass.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int COL       = 8,
    parameter int ROW       = 8,
    parameter int DRAIN_CYC = 16,
    parameter int AW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] w_base,
    input  logic [AW-1:0] x_base,
    input  logic [AW-1:0] p_base,
    input  logic [AW-1:0] n_act,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic          busy,
    output logic          done
);

    // Lane count is fixed by the xmem word packing. No sequencing step depends on it.
    localparam int ROW_UNUSED = ROW;

    localparam logic [AW-1:0] COL_L   = AW'(COL);
    localparam logic [AW-1:0] DRAIN_L = AW'(DRAIN_CYC);

    state_t        state;
    logic [AW-1:0] w_base_q, x_base_q, p_base_q, n_q;
    logic [AW-1:0] cnt;
    logic          xrd_q;
    logic          wr_pend;
    logic          accept;

    logic          x_clr, x_inc, x_last;
    logic          p_clr, p_inc, p_last;
    logic [AW-1:0] x_addr, p_addr, x_base_sel, x_limit;
    logic [33:0]   inst_nxt;

    assign accept = (state == S_IDLE) && !busy && start;

    // The xmem stream serves weights first, then activations.
    always_comb begin
        x_base_sel = (state == S_X_RD) ? x_base_q : w_base_q;
        x_limit    = (state == S_W_RD) ? COL_L    : n_q;
    end

    seq_addr_cnt #(.AW(AW)) u_xmem_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (x_clr),
        .inc   (x_inc),
        .base  (x_base_sel),
        .limit (x_limit),
        .addr  (x_addr),
        .last  (x_last)
    );

    seq_addr_cnt #(.AW(AW)) u_pmem_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (p_clr),
        .inc   (p_inc),
        .base  (p_base_q),
        .limit (n_q),
        .addr  (p_addr),
        .last  (p_last)
    );

    // Next instruction word: the current state's command plus the writes left over from the
    // previous cycle (SRAM read -> L0 write, OFIFO read -> psum write).
    always_comb begin
        inst_nxt = INST_IDLE;
        x_clr    = 1'b0;
        x_inc    = 1'b0;
        p_clr    = 1'b0;
        p_inc    = wr_pend;
        if (xrd_q) begin
            inst_nxt[INST_L0_WR] = 1'b1;
        end
        if (wr_pend) begin
            inst_nxt[INST_CEN_P] = 1'b0;
            inst_nxt[INST_WEN_P] = 1'b0;
            inst_nxt[INST_A_P_LSB +: AW] = p_addr;
        end
        case (state)
            S_ARM: begin
                x_clr = 1'b1;
                p_clr = 1'b1;
            end
            S_W_RD, S_X_RD: begin
                inst_nxt[INST_CEN_X] = 1'b0;
                inst_nxt[INST_A_X_LSB +: AW] = x_addr;
                x_inc = 1'b1;
                x_clr = x_last;
            end
            S_W_LD: begin
                inst_nxt[INST_L0_RD] = 1'b1;
                inst_nxt[INST_LOAD]  = 1'b1;
            end
            S_EXEC: begin
                inst_nxt[INST_L0_RD] = 1'b1;
                inst_nxt[INST_EXEC]  = 1'b1;
            end
            S_WB: begin
                if (ofifo_valid && (cnt != n_q)) begin
                    inst_nxt[INST_OFIFO_RD] = 1'b1;
                end
                // The last psum write has already issued. Rewind the stream for read-back.
                if (cnt == n_q) begin
                    p_clr = 1'b1;
                end
            end
`ifdef SEQ_SFP_RD_EN
            S_SFP_RD: begin
                inst_nxt[INST_CEN_P] = 1'b0;
                inst_nxt[INST_A_P_LSB +: AW] = p_addr;
                inst_nxt[INST_ACC]   = 1'b1;
                p_inc = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // Tile FSM. It also registers the inst word, the pending-write flags, busy and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            inst     <= INST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            xrd_q    <= 1'b0;
            wr_pend  <= 1'b0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            n_q      <= '0;
        end else begin
            inst    <= inst_nxt;
            xrd_q   <= ~inst_nxt[INST_CEN_X];
            wr_pend <= inst_nxt[INST_OFIFO_RD];
            busy    <= accept || (state != S_IDLE);
            done    <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        w_base_q <= w_base;
                        x_base_q <= x_base;
                        p_base_q <= p_base;
                        n_q      <= n_act;
                        cnt      <= '0;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    state <= S_W_RD;
                end
                S_W_RD: begin
                    if (x_last) begin
                        cnt   <= '0;
                        state <= S_W_LD;
                    end
                end
                S_W_LD: begin
                    if (cnt == COL_L - AW'(1)) begin
                        cnt   <= '0;
                        state <= S_W_DRAIN;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                S_W_DRAIN: begin
                    if (cnt == DRAIN_L - AW'(1)) begin
                        cnt   <= '0;
                        state <= (n_q == '0) ? S_DONE : S_X_RD;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                S_X_RD: begin
                    if (x_last) begin
                        cnt   <= '0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == n_q - AW'(1)) begin
                        cnt   <= '0;
                        state <= S_WB;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                S_WB: begin
                    // cnt counts OFIFO reads. The state is left once every read has issued.
                    if (cnt == n_q) begin
                        cnt <= '0;
`ifdef SEQ_SFP_RD_EN
                        state <= S_SFP_RD;
`else
                        state <= S_DONE;
`endif
                    end else if (ofifo_valid) begin
                        cnt <= cnt + AW'(1);
                    end
                end
                S_SFP_RD: begin
                    if (p_last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
